mix_columns_iter: RTL
=====================

MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream (row-shift stage) presents a block on data_in.
REQ-005 in_ready  output  1  block can accept a new input this cycle.
REQ-006 data_in  input  132  [131:128] header, [127:0] AES state.
REQ-007 bypass  input  1  sampled with data_in; 1 = final round, skip MixColumns.
REQ-008 out_valid  output  1  data_out holds a finished block.
REQ-009 out_ready  input  1  downstream consumes data_out this cycle.
REQ-010 data_out  output  132  registered result, [131:128] header, [127:0] state.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 State layout SHALL be: column c (0..3) = bits [c*32 +: 32]; row r byte of column c = bits [c*32 + r*8 +: 8].
REQ-013 FSM states SHALL be IDLE, CALC, DONE; in_ready = 1 only in IDLE.
REQ-014 Accept SHALL occur on a rising edge with in_valid & in_ready: data_in and bypass are captured into an internal 132-bit register.
REQ-015 On accept with bypass = 0, the FSM SHALL go IDLE -> CALC with a 2-bit column counter cleared to 0.
REQ-016 On accept with bypass = 1, the FSM SHALL go IDLE -> DONE; data_out = captured data unchanged.
REQ-017 In CALC, each cycle SHALL transform exactly one column (index = counter) in place, then increment the counter.
REQ-018 After the column 3 edge, the FSM SHALL go CALC -> DONE; the counter wraps to 0.
REQ-019 Column transform on bytes s0..s3 (row 0..3) SHALL be:
  s0' = 2*s0 ^ 3*s1 ^ s2 ^ s3
  s1' = s0 ^ 2*s1 ^ 3*s2 ^ s3
  s2' = s0 ^ s1 ^ 2*s2 ^ 3*s3
  s3' = 3*s0 ^ s1 ^ s2 ^ 2*s3
REQ-020 GF(2^8) multiply: 2*x = {x[6:0],0} ^ (x[7] ? 8'h1B : 0); 3*x = 2*x ^ x. All results 8 bits, no carries.
REQ-021 The header [131:128] SHALL pass through unmodified in all modes.
REQ-022 Latency SHALL be: out_valid rises 5 edges after the accept edge (non-bypass), 1 edge after (bypass).
REQ-023 out_valid SHALL be 1 only in DONE; data_out SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-024 In DONE with out_ready = 1, the FSM SHALL go to IDLE on that edge; out_valid falls next cycle.
REQ-025 No new accept SHALL occur in the DONE->IDLE cycle; minimum spacing is 6 cycles non-bypass, 2 cycles bypass.
REQ-026 in_valid while not in IDLE SHALL be ignored; upstream holds data until in_ready.
REQ-027 bypass and data_in changes after accept SHALL NOT affect the block in flight.
REQ-028 out_ready while not in DONE SHALL be ignored.

Reset
REQ-029 On n_rst = 0, asynchronously: state = IDLE, counter = 0, internal register and data_out = 0, out_valid = 0, busy = 0; in_ready = 1 once in IDLE.
REQ-030 Reset asserted during CALC or DONE SHALL discard the in-flight block; no partial result is ever presented.

Verification
REQ-031 Column 0 bytes r0..r3 = db,13,53,45, bypass = 0 -> column 0 of data_out = 8e,4d,a1,bc; out_valid 5 edges after accept.
REQ-032 Columns 0..3 = (f2,0a,22,5c), (01,01,01,01), (c6,c6,c6,c6), (d4,d4,d4,d5) -> (9f,dc,58,9d), (01,01,01,01), (c6,c6,c6,c6), (d5,d5,d7,d6); header 4'hA preserved.
REQ-033 bypass = 1, data_in = 132'h5_0123...EF -> identical data_out, out_valid 1 edge after accept, busy high 1 cycle only.
REQ-034 out_ready held 0 for 10 cycles in DONE -> data_out and out_valid stable, in_ready = 0, second in_valid ignored until release.
REQ-035 n_rst pulsed low during CALC counter = 2 -> all outputs 0 immediately, in_ready = 1 after release, next block processed correctly.
REQ-036 Column (2d,26,31,4c) with in_valid held high continuously -> result 4d,7e,bd,f8; accepts exactly every 6 cycles.

Source files
------------

// File: rtl/mix_columns_iter_if.sv
// Handshake bundle for the iterative MixColumns stage: upstream block input,
// downstream result output and the busy flag.
interface mix_columns_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [131:0] data_in;
  logic         bypass;
  logic         out_valid;
  logic         out_ready;
  logic [131:0] data_out;
  logic         busy;

  // Upstream producer plus downstream consumer side.
  modport master (
    output in_valid, data_in, bypass, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  // The MixColumns block itself.
  modport slave (
    input  in_valid, data_in, bypass, out_ready,
    output in_ready, out_valid, data_out, busy
  );
endinterface

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: one column per clock, four cycles per block.
// The 4-bit header passes through; bypass skips the transform (final round).
module mix_columns_iter (
  input  logic           clk,
  input  logic           n_rst,
  mix_columns_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t       state, state_nxt;
  logic [1:0]   col_cnt;
  logic [131:0] blk;
  logic         accept;

  // GF(2^8) doubling with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] s0, s1, s2, s3;
    logic [7:0] d0, d1, d2, d3;
    s0 = col[7:0];
    s1 = col[15:8];
    s2 = col[23:16];
    s3 = col[31:24];
    d0 = xtime(s0);
    d1 = xtime(s1);
    d2 = xtime(s2);
    d3 = xtime(s3);
    return {d0 ^ s0 ^ s1 ^ s2 ^ d3,
            s0 ^ s1 ^ d2 ^ d3 ^ s3,
            s0 ^ d1 ^ d2 ^ s2 ^ s3,
            d0 ^ d1 ^ s1 ^ s2 ^ s3};
  endfunction

  assign accept        = bus.in_valid && (state == IDLE);
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.data_out  = blk;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bus.bypass ? DONE : CALC;
      CALC:    if (col_cnt == 2'd3) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values together.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      col_cnt <= 2'd0;
      blk     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            blk     <= bus.data_in;
            col_cnt <= 2'd0;
          end
        end
        CALC: begin
          // Column transform in place; the counter wraps to 0 after column 3.
          blk[{col_cnt, 5'b0} +: 32] <= mix_col(blk[{col_cnt, 5'b0} +: 32]);
          col_cnt                    <= col_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
